// File: rtl/mlp_tile_scheduler_pkg.sv
// ============================================================================
//  Module      : mlp_sched_pkg
//  Description : Shared types for the MLP tile scheduler (state encoding,
//                tile descriptor) and default geometry constants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mlp_sched_pkg;

    localparam int c_NUM_LAYERS       = 2;
    localparam int c_MAX_WEIGHTS_SIZE = 32;
    localparam int c_MAX_COL_ROW_BITS = 6;
    localparam int c_LAYER_BITS       = 2;
    localparam int c_MEM_ADDR_WIDTH   = 3;

    typedef enum logic [6:0] {
        S_IDLE    = 7'b000_0001,
        S_SIZE    = 7'b000_0010,
        S_FETCH   = 7'b000_0100,
        S_ISSUE   = 7'b000_1000,
        S_ADVANCE = 7'b001_0000,
        S_FINISH  = 7'b010_0000,
        S_ERR     = 7'b100_0000
    } sched_state_t;

    typedef struct packed {
        logic [c_LAYER_BITS-1:0]       layer;
        logic [c_MAX_COL_ROW_BITS-1:0] row_base;
        logic [c_MAX_COL_ROW_BITS-1:0] rows;
        logic [c_MAX_COL_ROW_BITS-1:0] cols;
    } tile_desc_t;

endpackage

`default_nettype wire

// File: rtl/mlp_tile_scheduler_if.sv
// ============================================================================
//  Module      : mlp_tile_scheduler_if
//  Description : Control, BRAM-read and tile-descriptor bundle between the
//                scheduler (master) and the BRAM/datapath side (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mlp_tile_scheduler_if
    import mlp_sched_pkg::*;
#(
    parameter int NUM_LAYERS       = c_NUM_LAYERS,
    parameter int MAX_COL_ROW_BITS = c_MAX_COL_ROW_BITS,
    parameter int LAYER_BITS       = c_LAYER_BITS,
    parameter int MEM_ADDR_WIDTH   = c_MEM_ADDR_WIDTH
) ();

    logic                                          start;
    logic [NUM_LAYERS-1:0][MAX_COL_ROW_BITS-1:0]   rows_cfg;
    logic [NUM_LAYERS-1:0][MAX_COL_ROW_BITS-1:0]   cols_cfg;
    logic                                          bram_rd_en;
    logic [MEM_ADDR_WIDTH-1:0]                     bram_rd_addr;
    logic                                          bram_data_ready;
    logic                                          tile_valid;
    logic [LAYER_BITS-1:0]                         tile_layer;
    logic [MAX_COL_ROW_BITS-1:0]                   tile_row_base;
    logic [MAX_COL_ROW_BITS-1:0]                   tile_rows;
    logic [MAX_COL_ROW_BITS-1:0]                   tile_cols;
    logic                                          layer_done;
    logic                                          busy;
    logic                                          done;
    logic                                          cfg_err;

    modport master (
        input  start, rows_cfg, cols_cfg, bram_data_ready,
        output bram_rd_en, bram_rd_addr, tile_valid, tile_layer, tile_row_base,
               tile_rows, tile_cols, layer_done, busy, done, cfg_err
    );

    modport slave (
        output start, rows_cfg, cols_cfg, bram_data_ready,
        input  bram_rd_en, bram_rd_addr, tile_valid, tile_layer, tile_row_base,
               tile_rows, tile_cols, layer_done, busy, done, cfg_err
    );

endinterface

`default_nettype wire

// File: rtl/mlp_tile_divider.sv
// ============================================================================
//  Module      : mlp_tile_divider
//  Description : Iterative DIVIDEND / divisor by repeated subtraction, one
//                subtract per cycle; done is high in the exit cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mlp_tile_divider #(
    parameter int DIVIDEND = 32,
    parameter int WIDTH    = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam logic [WIDTH-1:0] c_DIVIDEND = WIDTH'(DIVIDEND);

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic             r_active;
    logic             w_ge;

    assign w_ge     = (r_rem >= divisor);
    assign done     = r_active && !w_ge;
    assign quotient = r_quot;

    // A zero divisor never terminates on its own; the caller aborts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem    <= '0;
            r_quot   <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_rem    <= c_DIVIDEND;
            r_quot   <= '0;
            r_active <= 1'b1;
        end else if (abort) begin
            r_active <= 1'b0;
        end else if (r_active) begin
            if (w_ge) begin
                r_rem  <= r_rem - divisor;
                r_quot <= r_quot + 1'b1;
            end else begin
                r_active <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mlp_tile_scheduler.sv
// ============================================================================
//  Module      : mlp_tile_scheduler
//  Description : Sequences weight-BRAM reads and row-tile descriptors across
//                all MLP layers. Optional BRAM watchdog: MLP_SCHED_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mlp_tile_scheduler
    import mlp_sched_pkg::*;
#(
    parameter int NUM_LAYERS       = c_NUM_LAYERS,
    parameter int MAX_WEIGHTS_SIZE = c_MAX_WEIGHTS_SIZE,
    parameter int MAX_COL_ROW_BITS = c_MAX_COL_ROW_BITS,
    parameter int LAYER_BITS       = c_LAYER_BITS,
    parameter int MEM_ADDR_WIDTH   = c_MEM_ADDR_WIDTH
`ifdef MLP_SCHED_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mlp_tile_scheduler_if.master bus
);

    localparam int c_DW = $clog2(MAX_WEIGHTS_SIZE + 1);
    localparam int c_QW = ((c_DW > MAX_COL_ROW_BITS) ? c_DW : MAX_COL_ROW_BITS) + 1;
    localparam logic [c_QW-1:0]       c_MAX_W      = c_QW'(MAX_WEIGHTS_SIZE);
    localparam logic [LAYER_BITS-1:0] c_LAST_LAYER = LAYER_BITS'(NUM_LAYERS - 1);

    sched_state_t                r_state, w_next;
    logic [LAYER_BITS-1:0]       r_layer;
    logic [MEM_ADDR_WIDTH-1:0]   r_addr;
    logic [MAX_COL_ROW_BITS-1:0] r_row_base, r_rows, r_cols;
    logic [c_QW-1:0]             r_rpt;
    logic                        r_rd_sent;

    logic [MAX_COL_ROW_BITS-1:0] w_cfg_rows, w_cfg_cols, w_left, w_tile_rows;
    logic [MAX_COL_ROW_BITS:0]   w_row_end;
    logic                        w_cfg_bad, w_layer_last, w_div_start, w_div_done, w_timeout;
    logic [c_QW-1:0]             w_quot;
    tile_desc_t                  w_tile;

    always_comb begin
        w_cfg_rows = '0;
        w_cfg_cols = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (r_layer == LAYER_BITS'(i)) begin
                w_cfg_rows = bus.rows_cfg[i];
                w_cfg_cols = bus.cols_cfg[i];
            end
        end
    end

    assign w_cfg_bad = (w_cfg_cols == '0) || (w_cfg_rows == '0) ||
                       (c_QW'(w_cfg_cols) > c_MAX_W);

    // Last tile of a layer is clipped to the rows that remain.
    assign w_left       = r_rows - r_row_base;
    assign w_tile_rows  = (c_QW'(w_left) < r_rpt) ? w_left : r_rpt[MAX_COL_ROW_BITS-1:0];
    assign w_row_end    = {1'b0, r_row_base} + {1'b0, w_tile_rows};
    assign w_layer_last = (w_row_end == {1'b0, r_rows});

    mlp_tile_divider #(
        .DIVIDEND (MAX_WEIGHTS_SIZE),
        .WIDTH    (c_QW)
    ) u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (w_div_start),
        .abort    (r_state == S_ERR),
        .divisor  (c_QW'(w_cfg_cols)),
        .done     (w_div_done),
        .quotient (w_quot)
    );

`ifdef MLP_SCHED_TIMEOUT_EN
    localparam int c_TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TO_LAST = c_TW'(TIMEOUT_CYCLES - 1);
    logic [c_TW-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  r_to_cnt <= '0;
        else if (r_state == S_FETCH) r_to_cnt <= r_to_cnt + 1'b1;
        else                         r_to_cnt <= '0;
    end

    assign w_timeout = (r_state == S_FETCH) && (r_to_cnt == c_TO_LAST);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_div_start = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next      = S_SIZE;
                    w_div_start = 1'b1;
                end
            end
            S_SIZE: begin
                if (w_cfg_bad)       w_next = S_ERR;
                else if (w_div_done) w_next = S_FETCH;
            end
            S_FETCH: begin
                if (bus.bram_data_ready) w_next = S_ISSUE;
                else if (w_timeout)      w_next = S_ERR;
            end
            S_ISSUE:   w_next = S_ADVANCE;
            S_ADVANCE: begin
                if (!w_layer_last) begin
                    w_next = S_FETCH;
                end else if (r_layer < c_LAST_LAYER) begin
                    w_next      = S_SIZE;
                    w_div_start = 1'b1;
                end else begin
                    w_next = S_FINISH;
                end
            end
            S_FINISH: w_next = S_IDLE;
            S_ERR:    w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Layer geometry is latched when sizing completes so tile fields stay put.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_layer    <= '0;
            r_addr     <= '0;
            r_row_base <= '0;
            r_rows     <= '0;
            r_cols     <= '0;
            r_rpt      <= '0;
            r_rd_sent  <= 1'b0;
        end else begin
            r_rd_sent <= (r_state == S_FETCH);
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_layer <= '0;
                        r_addr  <= '0;
                    end
                end
                S_SIZE: begin
                    if (!w_cfg_bad && w_div_done) begin
                        r_rpt      <= w_quot;
                        r_rows     <= w_cfg_rows;
                        r_cols     <= w_cfg_cols;
                        r_row_base <= '0;
                    end
                end
                S_ADVANCE: begin
                    r_addr <= r_addr + 1'b1;
                    if (!w_layer_last)                r_row_base <= r_row_base + w_tile_rows;
                    else if (r_layer < c_LAST_LAYER)  r_layer    <= r_layer + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_tile          = '0;
        w_tile.layer    = r_layer;
        w_tile.row_base = r_row_base;
        w_tile.rows     = w_tile_rows;
        w_tile.cols     = r_cols;
    end

    assign bus.bram_rd_en    = (r_state == S_FETCH) && !r_rd_sent;
    assign bus.bram_rd_addr  = r_addr;
    assign bus.tile_valid    = (r_state == S_ISSUE);
    assign bus.tile_layer    = w_tile.layer;
    assign bus.tile_row_base = w_tile.row_base;
    assign bus.tile_rows     = w_tile.rows;
    assign bus.tile_cols     = w_tile.cols;
    assign bus.layer_done    = (r_state == S_ISSUE) && w_layer_last;
    assign bus.busy          = !((r_state == S_IDLE) || (r_state == S_FINISH) || (r_state == S_ERR));
    assign bus.done          = (r_state == S_FINISH);
    assign bus.cfg_err       = (r_state == S_ERR);

endmodule

`default_nettype wire

// File: tb/tb_mlp_tile_scheduler.sv
// ============================================================================
//  Module      : tb_mlp_tile_scheduler
//  Description : Directed-vector bench for mlp_tile_scheduler with a simple
//                BRAM responder and per-tile capture.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mlp_tile_scheduler;

    logic clk;
    logic rst_n;

    mlp_tile_scheduler_if bus_if ();

    mlp_tile_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [28:0] w_outs;
    logic [19:0] w_fields;
    assign w_outs   = {bus_if.bram_rd_en, bus_if.bram_rd_addr, bus_if.tile_valid, bus_if.tile_layer,
                       bus_if.tile_row_base, bus_if.tile_rows, bus_if.tile_cols, bus_if.layer_done,
                       bus_if.busy, bus_if.done, bus_if.cfg_err};
    assign w_fields = {bus_if.tile_layer, bus_if.tile_row_base, bus_if.tile_rows, bus_if.tile_cols};

    int n_vec  = 0;
    int n_miss = 0;

    int t_layer[16], t_base[16], t_rows[16], t_cols[16], t_ld[16], t_addr[16], t_cyc[16];
    int n_tiles, n_done, n_err, n_rd, first_rd, err_cyc, unstable, busy_gap;
    int ended;
    logic [28:0] rst_snap;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_tile(input string tag, input int idx, input int layer, input int base,
                            input int rows, input int cols, input int ld, input int addr);
        chk({tag, "_layer"}, t_layer[idx], layer);
        chk({tag, "_base"},  t_base[idx],  base);
        chk({tag, "_rows"},  t_rows[idx],  rows);
        chk({tag, "_cols"},  t_cols[idx],  cols);
        chk({tag, "_ldone"}, t_ld[idx],    ld);
        chk({tag, "_addr"},  t_addr[idx],  addr);
    endtask

    task automatic set_cfg(input int r0, input int r1, input int c0, input int c1);
        bus_if.rows_cfg[0] = 6'(r0);
        bus_if.rows_cfg[1] = 6'(r1);
        bus_if.cols_cfg[0] = 6'(c0);
        bus_if.cols_cfg[1] = 6'(c1);
    endtask

    // Cycle index 0 is the negedge at which start is driven; the responder
    // raises ready dly cycles after seeing the read strobe.
    task automatic run_inf(input int dly, input int restart_at, input int rst_at, input int budget);
        int pend = -1;
        int tail = -1;
        int cur_addr = 0;
        bit in_run = 1'b0;
        bit in_fetch = 1'b0;
        logic [19:0] snap = '0;
        n_tiles = 0; n_done = 0; n_err = 0; n_rd = 0; first_rd = -1; err_cyc = -1;
        unstable = 0; busy_gap = 0; ended = 0;
        for (int cyc = 0; cyc < budget && tail != 0; cyc++) begin
            @(negedge clk);
            if (bus_if.bram_rd_en) begin
                n_rd++;
                if (first_rd < 0) first_rd = cyc;
                cur_addr = int'(bus_if.bram_rd_addr);
                snap     = w_fields;
                pend     = dly;
                in_fetch = 1'b1;
            end else if (in_fetch && w_fields != snap) begin
                unstable++;
            end
            if (bus_if.tile_valid) begin
                if (n_tiles < 16) begin
                    t_layer[n_tiles] = int'(bus_if.tile_layer);
                    t_base[n_tiles]  = int'(bus_if.tile_row_base);
                    t_rows[n_tiles]  = int'(bus_if.tile_rows);
                    t_cols[n_tiles]  = int'(bus_if.tile_cols);
                    t_ld[n_tiles]    = int'(bus_if.layer_done);
                    t_addr[n_tiles]  = cur_addr;
                    t_cyc[n_tiles]   = cyc;
                end
                n_tiles++;
                in_fetch = 1'b0;
            end
            if (bus_if.done) begin
                n_done++;
                if (bus_if.busy) busy_gap++;
            end
            if (bus_if.cfg_err) begin
                n_err++;
                err_cyc = cyc;
                if (bus_if.busy) busy_gap++;
            end
            if (in_run && !bus_if.busy && !bus_if.done && !bus_if.cfg_err) busy_gap++;
            if (bus_if.done || bus_if.cfg_err) begin
                in_run = 1'b0;
                ended  = 1;
                if (tail < 0) tail = 12;
            end
            if (tail > 0) tail--;

            bus_if.bram_data_ready = 1'b0;
            if (pend == 0) begin
                bus_if.bram_data_ready = 1'b1;
                pend = -1;
            end else if (pend > 0) begin
                pend--;
            end
            bus_if.start = (cyc == 0) || (cyc == restart_at);
            if (cyc == 0) in_run = 1'b1;
            if (cyc == rst_at) begin
                rst_n  = 1'b0;
                in_run = 1'b0;
                #1;
                rst_snap = w_outs;
            end else if (cyc == rst_at + 1) begin
                rst_n = 1'b1;
            end
        end
        bus_if.start           = 1'b0;
        bus_if.bram_data_ready = 1'b0;
    endtask

    initial begin
        rst_n                  = 1'b0;
        bus_if.start           = 1'b0;
        bus_if.bram_data_ready = 1'b0;
        set_cfg(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'(w_outs), 0);
        rst_n = 1'b1;

        // Two single-tile layers
        set_cfg(3, 1, 8, 3);
        run_inf(1, -1, -1, 200);
        chk("t1_end", ended, 1);
        chk("t1_tiles", n_tiles, 2);
        chk("t1_first_rd", first_rd, 6);
        chk_tile("t1_tile0", 0, 0, 0, 3, 8, 1, 0);
        chk_tile("t1_tile1", 1, 1, 0, 1, 3, 1, 1);
        chk("t1_tile1_cyc", t_cyc[1], 23);
        chk("t1_done", n_done, 1);
        chk("t1_err", n_err, 0);
        chk("t1_busy", busy_gap, 0);

        // Layer 0 split into two row tiles
        set_cfg(9, 1, 4, 9);
        run_inf(1, -1, -1, 200);
        chk("t2_end", ended, 1);
        chk("t2_tiles", n_tiles, 3);
        chk("t2_first_rd", first_rd, 10);
        chk_tile("t2_tile0", 0, 0, 0, 8, 4, 0, 0);
        chk_tile("t2_tile1", 1, 0, 8, 1, 4, 1, 1);
        chk_tile("t2_tile2", 2, 1, 0, 1, 9, 1, 2);
        chk("t2_tile1_cyc", t_cyc[1], 16);
        chk("t2_done", n_done, 1);

        // Illegal configurations
        set_cfg(3, 1, 0, 3);
        run_inf(1, -1, -1, 100);
        chk("t3a_err", n_err, 1);
        chk("t3a_err_cyc", err_cyc, 2);
        chk("t3a_tiles", n_tiles, 0);
        chk("t3a_rd", n_rd, 0);
        chk("t3a_done", n_done, 0);
        chk("t3a_busy", busy_gap, 0);

        set_cfg(3, 1, 8, 33);
        run_inf(1, -1, -1, 100);
        chk("t3b_err", n_err, 1);
        chk("t3b_err_cyc", err_cyc, 11);
        chk("t3b_tiles", n_tiles, 1);
        chk("t3b_done", n_done, 0);

        set_cfg(0, 1, 8, 3);
        run_inf(1, -1, -1, 100);
        chk("t3c_err_cyc", err_cyc, 2);
        chk("t3c_tiles", n_tiles, 0);

        set_cfg(3, 1, 8, 3);
        run_inf(1, -1, -1, 200);
        chk("t3d_done", n_done, 1);
        chk("t3d_tiles", n_tiles, 2);

        // Start while busy, with a long BRAM stall
        run_inf(10, 10, -1, 200);
        chk("t4a_done", n_done, 1);
        chk("t4a_tiles", n_tiles, 2);
        chk("t4a_rd", n_rd, 2);
        chk("t4a_stable", unstable, 0);
        chk("t4a_tile0_cyc", t_cyc[0], 17);
        chk("t4a_busy", busy_gap, 0);
        run_inf(1, 3, -1, 200);
        chk("t4b_done", n_done, 1);
        chk("t4b_tiles", n_tiles, 2);

        // Asynchronous reset while stalled in FETCH
        run_inf(10, -1, 8, 60);
        chk("t5_rst_outputs", int'(rst_snap), 0);
        chk("t5_end", ended, 0);
        chk("t5_done", n_done, 0);
        chk("t5_tiles", n_tiles, 0);
        run_inf(1, -1, -1, 200);
        chk("t5_after_done", n_done, 1);
        chk_tile("t5_tile0", 0, 0, 0, 3, 8, 1, 0);

        // Nine tiles: read address wraps 7 -> 0, ready on the strobe cycle
        set_cfg(8, 1, 32, 1);
        run_inf(0, -1, -1, 300);
        chk("t6_end", ended, 1);
        chk("t6_tiles", n_tiles, 9);
        chk("t6_first_rd", first_rd, 3);
        chk("t6_tile6_ldone", t_ld[6], 0);
        chk_tile("t6_tile7", 7, 0, 7, 1, 32, 1, 7);
        chk_tile("t6_tile8", 8, 1, 0, 1, 1, 1, 0);
        chk("t6_cadence", t_cyc[7] - t_cyc[6], 3);
        chk("t6_tile8_cyc", t_cyc[8], 61);
        chk("t6_err", n_err, 0);
        chk("t6_done", n_done, 1);

`ifdef MLP_SCHED_TIMEOUT_EN
        set_cfg(3, 1, 8, 3);
        run_inf(1000, -1, -1, 150);
        chk("t7_err", n_err, 1);
        chk("t7_err_cyc", err_cyc, 70);
        chk("t7_tiles", n_tiles, 0);
        chk("t7_done", n_done, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
